// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a pixel-enable divider drives the h/v counters.
// Sync, blank and coordinate outputs are registered and decoded from the counters' next values.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_ce,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX     = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic          H_ON        = 1'(H_POL);
  localparam logic          V_ON        = 1'(V_POL);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, br_q, br_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic          ce;
  logic          h_in, v_in;

  // rst_n gating keeps the strobe low during reset even when CLK_DIV=1
  assign ce = en & rst_n & (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (en) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    end
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Decoding the next counter values keeps outputs aligned with hCount/vCount.
  // When the counters hold, the decode reproduces the held values.
  always_comb begin
    hs_d = (h_d < H_SYNC_END) ? H_ON : ~H_ON;
    vs_d = (v_d < V_SYNC_END) ? V_ON : ~V_ON;
    h_in = (h_d >= H_ACT_START) && (h_d < H_ACT_END);
    v_in = (v_d >= V_ACT_START) && (v_d < V_ACT_END);
    br_d = h_in & v_in;
    x_d  = br_d ? h_d - H_ACT_START : '0;
    y_d  = br_d ? v_d - V_ACT_START : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= H_ON;
      vs_q  <= V_ON;
      br_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      br_q  <= br_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_ce      = ce;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign bright      = br_q;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;

endmodule
